exc_seq_ctrl: RTL

- Exception/interrupt sequencer in front of the CP0 register block.
- Collects syscall/break/teq/eret requests from decode and the external interrupt line, then arbitrates between them by fixed priority.
- Issues exactly one exception transaction at a time to CP0 (exception, eret, cause, pc), stalls the core while CP0 updates, then pulses a PC-load so fetch takes CP0's exc_addr.

---
 rtl/exc_seq_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt sequencer feeding CP0: latches requests, arbitrates, stalls, redirects fetch.
// Optional timer interrupt source enabled by defining EXC_SEQ_TIMER_EN.
module exc_seq_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter logic [4:0]  VEC_INTR_CAUSE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        req_eret,
    input  logic [31:0] req_pc,
    input  logic        intr,
    input  logic [31:0] cp0_status,
`ifdef EXC_SEQ_TIMER_EN
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
`endif
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        stall,
    output logic        pc_load,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REDIRECT} state_t;

    localparam logic [2:0] SRC_SYS  = 3'd0;
    localparam logic [2:0] SRC_BRK  = 3'd1;
    localparam logic [2:0] SRC_TEQ  = 3'd2;
    localparam logic [2:0] SRC_ERET = 3'd3;
    localparam logic [2:0] SRC_INT  = 3'd4;

    localparam logic [4:0] CAUSE_SYS = 5'b01000;
    localparam logic [4:0] CAUSE_BRK = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ = 5'b01101;
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  cur_src;
    logic [3:0]  pend;
    logic [31:0] pend_pc [4];
    logic [31:0] last_pc;
    logic        intr_s1, intr_s2, intr_armed;
    logic [3:0]  req_v;
    logic [3:0]  pend_clr;
    logic        int_ok;
    logic        issue_int;
    logic        win_valid;
    logic [2:0]  win_src;
    logic [4:0]  win_cause;
    logic [31:0] win_pc;
    logic        win_eret;
    logic        unused_status;

    assign req_v         = {req_eret, req_teq, req_break, req_syscall};
    assign unused_status = ^cp0_status[31:1];

    // Fixed priority over latched bits only; interrupt is the lowest-priority fallback.
    always_comb begin
        win_valid = 1'b1;
        win_src   = SRC_INT;
        win_cause = '0;
        win_pc    = '0;
        win_eret  = 1'b0;
        if (pend[3]) begin
            win_src  = SRC_ERET;
            win_pc   = pend_pc[3];
            win_eret = 1'b1;
        end else if (pend[2]) begin
            win_src   = SRC_TEQ;
            win_cause = CAUSE_TEQ;
            win_pc    = pend_pc[2];
        end else if (pend[1]) begin
            win_src   = SRC_BRK;
            win_cause = CAUSE_BRK;
            win_pc    = pend_pc[1];
        end else if (pend[0]) begin
            win_src   = SRC_SYS;
            win_cause = CAUSE_SYS;
            win_pc    = pend_pc[0];
        end else if (int_ok) begin
            win_cause = VEC_INTR_CAUSE;
            win_pc    = last_pc;
        end else begin
            win_valid = 1'b0;
        end
    end

    always_comb begin
        pend_clr = '0;
        if (state == ISSUE && cur_src != SRC_INT)
            pend_clr[cur_src[1:0]] = 1'b1;
    end

    assign issue_int = (state == IDLE) && win_valid && (win_src == SRC_INT);

    // A request landing on an already-set bit is lost, even on the clearing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            last_pc  <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                pend_pc[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (req_v[i] && pend[i])
                    overflow <= 1'b1;
                if (pend_clr[i])
                    pend[i] <= 1'b0;
                else if (req_v[i] && !pend[i]) begin
                    pend[i]    <= 1'b1;
                    pend_pc[i] <= req_pc;
                end
            end
            if (|req_v)
                last_pc <= req_pc;
        end
    end

    // One interrupt per asserted level: re-arm only once the synchronised line is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_s1    <= 1'b0;
            intr_s2    <= 1'b0;
            intr_armed <= 1'b1;
        end else begin
            intr_s1 <= intr;
            intr_s2 <= intr_s1;
            if (issue_int && intr_s2)
                intr_armed <= 1'b0;
            else if (!intr_s2)
                intr_armed <= 1'b1;
        end
    end

`ifdef EXC_SEQ_TIMER_EN
    logic [31:0] tmr_count;
    logic [31:0] tmr_cmp;
    logic        tmr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_count <= '0;
            tmr_cmp   <= '0;
            tmr_pend  <= 1'b0;
        end else begin
            tmr_count <= tmr_count + 32'd1;
            if (cmp_we) begin
                tmr_cmp  <= cmp_wdata;
                tmr_pend <= 1'b0;
            end else if (issue_int)
                tmr_pend <= 1'b0;
            else if (tmr_count == tmr_cmp && tmr_cmp != '0)
                tmr_pend <= 1'b1;
        end
    end

    assign int_ok = cp0_status[0] && ((intr_s2 && intr_armed) || tmr_pend);
`else
    assign int_ok = cp0_status[0] && intr_s2 && intr_armed;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_src       <= '0;
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            cp0_cause     <= '0;
            cp0_pc        <= '0;
            stall         <= 1'b0;
            pc_load       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state         <= ISSUE;
                        cur_src       <= win_src;
                        cp0_exception <= 1'b1;
                        cp0_eret      <= win_eret;
                        cp0_cause     <= win_cause;
                        cp0_pc        <= win_pc;
                        stall         <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ISSUE: begin
                    state         <= WAIT;
                    cnt           <= HOLD_LD;
                    cp0_exception <= 1'b0;
                    cp0_eret      <= 1'b0;
                    cp0_cause     <= '0;
                    cp0_pc        <= '0;
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state   <= REDIRECT;
                        pc_load <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state   <= IDLE;
                    pc_load <= 1'b0;
                    stall   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
